// File: rtl/midi_voice_alloc_pkg.sv
// Shared MIDI command codes and types for the voice allocator.
// The command codes are the ones midi_decoder emits.
package midi_voice_alloc_pkg;

  localparam int MIDI_CMD_SIZE = 4;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NOTE_OFF = 4'h8;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NOTE_ON  = 4'h9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_RESOLVE,
    ST_EMIT
  } state_t;

  // Latched note request; on=0 covers NOTE_OFF and NOTE_ON with velocity 0
  typedef struct packed {
    logic       on;
    logic [6:0] note;
    logic [6:0] vel;
  } note_msg_t;

endpackage

// File: rtl/midi_voice_alloc_voice_table.sv
// Voice slot storage: active flag, note and saturating age per voice.
// Asynchronous read port for the scanner and one update command per note event.
module midi_voice_alloc_voice_table
  import midi_voice_alloc_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int AGE_W      = 4,
  localparam int IDX_W     = $clog2(NUM_VOICES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_active,
  output logic [6:0]            rd_note,
  output logic [AGE_W-1:0]      rd_age,
  input  logic                  wr_en,
  input  logic                  wr_on,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [6:0]            wr_note,
  output logic [NUM_VOICES-1:0] active
);

  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [NUM_VOICES-1:0]            active_q;
  logic [NUM_VOICES-1:0][6:0]       note_q;
  logic [NUM_VOICES-1:0][AGE_W-1:0] age_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= '0;
      note_q   <= '0;
      age_q    <= '0;
    end else if (wr_en) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (wr_idx == IDX_W'(v)) begin
          if (wr_on) begin
            active_q[v] <= 1'b1;
            note_q[v]   <= wr_note;
            age_q[v]    <= '0;
          end else begin
            active_q[v] <= 1'b0;
          end
        // Only note-ons age the other voices; releases leave ages alone
        end else if (wr_on && active_q[v] && age_q[v] != AGE_MAX) begin
          age_q[v] <= age_q[v] + 1'b1;
        end
      end
    end
  end

  assign rd_active = active_q[rd_idx];
  assign rd_note   = note_q[rd_idx];
  assign rd_age    = age_q[rd_idx];
  assign active    = active_q;

endmodule

// File: rtl/midi_voice_alloc.sv
// Polyphonic voice allocator: serial scan of the voice table per note message,
// then one retrigger/allocate/steal or release event over valid/ready.
module midi_voice_alloc
  import midi_voice_alloc_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int MIDI_CH    = 0,
  parameter int AGE_W      = 4,
  localparam int IDX_W     = $clog2(NUM_VOICES)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     midi_rdy,
  input  logic [MIDI_CMD_SIZE-1:0] midi_cmd,
  input  logic [3:0]               midi_ch_sysn,
  input  logic [6:0]               midi_data0,
  input  logic [6:0]               midi_data1,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [IDX_W-1:0]         evt_voice,
  output logic                     evt_on,
  output logic [6:0]               evt_note,
  output logic [6:0]               evt_vel,
  output logic [NUM_VOICES-1:0]    voice_active,
  output logic                     drop_pulse
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VOICES - 1);

  state_t           state;
  note_msg_t        msg;
  logic [IDX_W-1:0] scan;
  logic             match_found, free_found, old_found;
  logic [IDX_W-1:0] match_idx, free_idx, old_idx;
  logic [AGE_W-1:0] old_age;

  logic             rd_active;
  logic [6:0]       rd_note;
  logic [AGE_W-1:0] rd_age;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic             note_msg;

  assign note_msg = midi_rdy && (midi_ch_sysn == 4'(MIDI_CH)) &&
                    (midi_cmd == MIDI_CMD_NOTE_ON || midi_cmd == MIDI_CMD_NOTE_OFF);

  midi_voice_alloc_voice_table #(
    .NUM_VOICES (NUM_VOICES),
    .AGE_W      (AGE_W)
  ) u_table (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (scan),
    .rd_active (rd_active),
    .rd_note   (rd_note),
    .rd_age    (rd_age),
    .wr_en     (wr_en),
    .wr_on     (msg.on),
    .wr_idx    (wr_idx),
    .wr_note   (msg.note),
    .active    (voice_active)
  );

  // Target selection: match, then free, then oldest (all busy when no free)
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = match_idx;
    if (state == ST_RESOLVE) begin
      if (msg.on) begin
        wr_en  = 1'b1;
        wr_idx = match_found ? match_idx : (free_found ? free_idx : old_idx);
      end else begin
        wr_en  = match_found;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      msg         <= '0;
      scan        <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      old_found   <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      old_idx     <= '0;
      old_age     <= '0;
      evt_valid   <= 1'b0;
      evt_voice   <= '0;
      evt_on      <= 1'b0;
      evt_note    <= '0;
      evt_vel     <= '0;
      drop_pulse  <= 1'b0;
    end else begin
      drop_pulse <= note_msg && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (note_msg) begin
            msg.on      <= (midi_cmd == MIDI_CMD_NOTE_ON) && (midi_data1 != 7'd0);
            msg.note    <= midi_data0;
            msg.vel     <= midi_data1;
            scan        <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            old_found   <= 1'b0;
            state       <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (rd_active && rd_note == msg.note && !match_found) begin
            match_found <= 1'b1;
            match_idx   <= scan;
          end
          if (!rd_active && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= scan;
          end
          // Strict compare keeps the lowest index on age ties
          if (rd_active && (!old_found || rd_age > old_age)) begin
            old_found <= 1'b1;
            old_idx   <= scan;
            old_age   <= rd_age;
          end
          if (scan == LAST) state <= ST_RESOLVE;
          else              scan  <= scan + 1'b1;
        end
        ST_RESOLVE: begin
          if (wr_en) begin
            evt_valid <= 1'b1;
            evt_voice <= wr_idx;
            evt_on    <= msg.on;
            evt_note  <= msg.note;
            evt_vel   <= msg.on ? msg.vel : 7'd0;
            state     <= ST_EMIT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_EMIT: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Directed bench for midi_voice_alloc with 8 voices on channel 0.
module tb_midi_voice_alloc;
  import midi_voice_alloc_pkg::*;

  localparam int NV = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       midi_rdy = 1'b0;
  logic [3:0] midi_cmd = '0;
  logic [3:0] midi_ch_sysn = '0;
  logic [6:0] midi_data0 = '0;
  logic [6:0] midi_data1 = '0;
  logic       evt_valid;
  logic       evt_ready = 1'b1;
  logic [2:0] evt_voice;
  logic       evt_on;
  logic [6:0] evt_note;
  logic [6:0] evt_vel;
  logic [7:0] voice_active;
  logic       drop_pulse;

  int passed = 0;
  int total = 0;
  int hs_cnt = 0;
  int drop_cnt = 0;

  midi_voice_alloc #(.NUM_VOICES(NV), .MIDI_CH(0), .AGE_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .midi_rdy     (midi_rdy),
    .midi_cmd     (midi_cmd),
    .midi_ch_sysn (midi_ch_sysn),
    .midi_data0   (midi_data0),
    .midi_data1   (midi_data1),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_voice    (evt_voice),
    .evt_on       (evt_on),
    .evt_note     (evt_note),
    .evt_vel      (evt_vel),
    .voice_active (voice_active),
    .drop_pulse   (drop_pulse)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after posedge, so the negedge sees stable values
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) hs_cnt++;
    if (!reset && drop_pulse) drop_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic send(input logic [3:0] cmd, input logic [3:0] ch,
                      input logic [6:0] note, input logic [6:0] vel);
    midi_cmd     = cmd;
    midi_ch_sysn = ch;
    midi_data0   = note;
    midi_data1   = vel;
    midi_rdy     = 1'b1;
    tick;
    midi_rdy     = 1'b0;
  endtask

  task automatic wait_evt(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (evt_valid) ok = 1'b1;
      else tick;
    end
  endtask

  task automatic test_reset;
    evt_ready = 1'b1;
    do_reset;
    total++; if (evt_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", evt_valid); else passed++;
    total++; if (evt_voice !== 3'd0) $display("FAIL reset_voice: got %0d want 0", evt_voice); else passed++;
    total++; if ({evt_on, evt_note, evt_vel} !== 15'd0)
      $display("FAIL reset_evt: got %0h want 0", {evt_on, evt_note, evt_vel}); else passed++;
    total++; if (voice_active !== 8'h00) $display("FAIL reset_active: got %0h want 0", voice_active); else passed++;
    total++; if (drop_pulse !== 1'b0) $display("FAIL reset_drop: got %0b want 0", drop_pulse); else passed++;
  endtask

  task automatic test_single;
    int hs0;
    do_reset;
    hs0 = hs_cnt;
    send(MIDI_CMD_NOTE_ON, 4'd0, 7'd60, 7'd100);
    repeat (NV) tick;
    total++; if (evt_valid !== 1'b0) $display("FAIL single_early: got %0b want 0", evt_valid); else passed++;
    tick;
    total++; if (evt_valid !== 1'b1) $display("FAIL single_latency: got %0b want 1", evt_valid); else passed++;
    total++; if (evt_voice !== 3'd0) $display("FAIL single_voice: got %0d want 0", evt_voice); else passed++;
    total++; if (evt_on !== 1'b1) $display("FAIL single_on: got %0b want 1", evt_on); else passed++;
    total++; if (evt_note !== 7'd60) $display("FAIL single_note: got %0d want 60", evt_note); else passed++;
    total++; if (evt_vel !== 7'd100) $display("FAIL single_vel: got %0d want 100", evt_vel); else passed++;
    total++; if (voice_active !== 8'h01) $display("FAIL single_active: got %0h want 01", voice_active); else passed++;
    tick;
    total++; if (evt_valid !== 1'b0) $display("FAIL single_clear: got %0b want 0", evt_valid); else passed++;
    repeat (NV + 4) tick;
    total++; if (hs_cnt - hs0 !== 1) $display("FAIL single_count: got %0d want 1", hs_cnt - hs0); else passed++;
  endtask

  task automatic test_steal;
    logic ok;
    int hs0;
    do_reset;
    for (int i = 0; i < NV; i++) begin
      send(MIDI_CMD_NOTE_ON, 4'd0, 7'(60 + i), 7'd100);
      wait_evt(ok);
      total++; if (!ok || evt_voice !== 3'(i))
        $display("FAIL steal_alloc%0d: got ok=%0b voice=%0d want voice %0d", i, ok, evt_voice, i); else passed++;
      tick;
    end
    total++; if (voice_active !== 8'hff) $display("FAIL steal_full: got %0h want ff", voice_active); else passed++;
    hs0 = hs_cnt;
    send(MIDI_CMD_NOTE_ON, 4'd0, 7'd72, 7'd110);
    wait_evt(ok);
    total++; if (!ok || evt_voice !== 3'd0 || evt_on !== 1'b1 || evt_note !== 7'd72)
      $display("FAIL steal_evt: got ok=%0b voice=%0d on=%0b note=%0d want voice 0 on 1 note 72",
               ok, evt_voice, evt_on, evt_note); else passed++;
    tick;
    repeat (NV + 4) tick;
    total++; if (hs_cnt - hs0 !== 1) $display("FAIL steal_count: got %0d want 1", hs_cnt - hs0); else passed++;
  endtask

  task automatic test_note_off;
    logic ok;
    int hs0;
    do_reset;
    send(MIDI_CMD_NOTE_ON, 4'd0, 7'd60, 7'd100);
    wait_evt(ok);
    tick;
    hs0 = hs_cnt;
    send(MIDI_CMD_NOTE_ON, 4'd0, 7'd64, 7'd0);
    repeat (NV + 4) tick;
    total++; if (hs_cnt - hs0 !== 0) $display("FAIL off_nomatch: got %0d events want 0", hs_cnt - hs0); else passed++;
    send(MIDI_CMD_NOTE_OFF, 4'd0, 7'd60, 7'd64);
    wait_evt(ok);
    total++; if (!ok || evt_voice !== 3'd0 || evt_on !== 1'b0 || evt_note !== 7'd60 || evt_vel !== 7'd0)
      $display("FAIL off_evt: got ok=%0b voice=%0d on=%0b note=%0d vel=%0d want 0/0/60/0",
               ok, evt_voice, evt_on, evt_note, evt_vel); else passed++;
    total++; if (voice_active !== 8'h00) $display("FAIL off_active: got %0h want 00", voice_active); else passed++;
    tick;
    repeat (NV + 4) tick;
    total++; if (hs_cnt - hs0 !== 1) $display("FAIL off_count: got %0d want 1", hs_cnt - hs0); else passed++;
  endtask

  task automatic test_retrigger;
    logic ok;
    do_reset;
    send(MIDI_CMD_NOTE_ON, 4'd0, 7'd60, 7'd50);
    wait_evt(ok);
    tick;
    send(MIDI_CMD_NOTE_ON, 4'd0, 7'd60, 7'd90);
    wait_evt(ok);
    total++; if (!ok || evt_voice !== 3'd0 || evt_vel !== 7'd90 || evt_on !== 1'b1)
      $display("FAIL retrig_evt: got ok=%0b voice=%0d vel=%0d on=%0b want voice 0 vel 90 on 1",
               ok, evt_voice, evt_vel, evt_on); else passed++;
    total++; if (voice_active !== 8'h01) $display("FAIL retrig_active: got %0h want 01", voice_active); else passed++;
    tick;
  endtask

  task automatic test_back_to_back;
    logic ok;
    int hs0, dr0;
    do_reset;
    evt_ready = 1'b0;
    hs0 = hs_cnt;
    dr0 = drop_cnt;
    send(MIDI_CMD_NOTE_ON, 4'd0, 7'd60, 7'd100);
    wait_evt(ok);
    send(MIDI_CMD_NOTE_ON, 4'd0, 7'd62, 7'd80);
    repeat (3) tick;
    total++; if (!ok || evt_valid !== 1'b1 || evt_voice !== 3'd0 || evt_note !== 7'd60 || evt_vel !== 7'd100)
      $display("FAIL stall_hold: got valid=%0b voice=%0d note=%0d vel=%0d want 1/0/60/100",
               evt_valid, evt_voice, evt_note, evt_vel); else passed++;
    total++; if (drop_cnt - dr0 !== 1) $display("FAIL stall_drop: got %0d want 1", drop_cnt - dr0); else passed++;
    evt_ready = 1'b1;
    tick;
    total++; if (evt_valid !== 1'b0) $display("FAIL stall_release: got %0b want 0", evt_valid); else passed++;
    repeat (NV + 4) tick;
    total++; if (hs_cnt - hs0 !== 1) $display("FAIL stall_count: got %0d want 1", hs_cnt - hs0); else passed++;
    total++; if (voice_active !== 8'h01) $display("FAIL stall_active: got %0h want 01", voice_active); else passed++;
  endtask

  task automatic test_filter_reset;
    int hs0, dr0;
    do_reset;
    hs0 = hs_cnt;
    dr0 = drop_cnt;
    send(MIDI_CMD_NOTE_ON, 4'd3, 7'd60, 7'd100);
    repeat (NV + 4) tick;
    total++; if (hs_cnt - hs0 !== 0 || evt_valid !== 1'b0)
      $display("FAIL filter_ch: got events=%0d valid=%0b want 0/0", hs_cnt - hs0, evt_valid); else passed++;
    send(MIDI_CMD_NOTE_ON, 4'd0, 7'd60, 7'd100);
    repeat (3) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    repeat (NV + 4) tick;
    total++; if (hs_cnt - hs0 !== 0 || evt_valid !== 1'b0)
      $display("FAIL abort_evt: got events=%0d valid=%0b want 0/0", hs_cnt - hs0, evt_valid); else passed++;
    total++; if (voice_active !== 8'h00) $display("FAIL abort_active: got %0h want 00", voice_active); else passed++;
    total++; if ({evt_voice, evt_on, evt_note, evt_vel} !== 18'd0)
      $display("FAIL abort_regs: got %0h want 0", {evt_voice, evt_on, evt_note, evt_vel}); else passed++;
    total++; if (drop_cnt - dr0 !== 0) $display("FAIL abort_drop: got %0d want 0", drop_cnt - dr0); else passed++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_steal;
    test_note_off;
    test_retrigger;
    test_back_to_back;
    test_filter_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/midi_voice_alloc.md
Name: midi_voice_alloc

Overview:
- Polyphonic voice allocator, downstream of midi_decoder and upstream of the multi-voice tone generator.
- Consumes decoded MIDI note-on/note-off messages for one channel and keeps a table of NUM_VOICES voices.
- Emits per-voice on/off events through a valid/ready handshake.
- Assigns free voices and steals the oldest voice when all voices are busy.

Parameters:
NUM_VOICES, 8, number of voice slots (2..16)
MIDI_CH, 0, MIDI channel accepted (0..15); messages on other channels are ignored
AGE_W, 4, width of saturating per-voice age counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
midi_rdy  in  1  one-cycle strobe: decoded message valid
midi_cmd  in  `MIDI_CMD_SIZE  decoded command code
midi_ch_sysn  in  4  channel number
midi_data0  in  7  note number
midi_data1  in  7  velocity
evt_valid  out  1  voice event pending
evt_ready  in  1  consumer accepts event
evt_voice  out  $clog2(NUM_VOICES)  target voice index
evt_on  out  1  1 = start/retrigger note, 0 = release
evt_note  out  7  note number
evt_vel  out  7  velocity (0 on release)
voice_active  out  NUM_VOICES  per-voice active flag
drop_pulse  out  1  one-cycle strobe: message lost because block busy

Behaviour:
- Reset: evt_valid=0, evt_voice=0, evt_on=0, evt_note=0, evt_vel=0, voice_active=0, drop_pulse=0, all ages=0, FSM=IDLE. Reset mid-operation aborts the search or pending event; nothing is emitted afterwards.
- Filter: a message is accepted only on midi_rdy=1 in IDLE, with midi_ch_sysn==MIDI_CH and midi_cmd equal to NOTE_ON or NOTE_OFF. Other messages are silently ignored, with no drop_pulse.
- NOTE_ON with velocity 0 is treated as NOTE_OFF.
- Accepted message: cmd/note/vel are latched and the FSM enters SEARCH.
- midi_rdy=1 for an otherwise acceptable message while the FSM is not IDLE: the message is discarded and drop_pulse=1 in the next cycle.
- FSM states:
  - IDLE: wait for an accepted message.
  - SEARCH: scan one voice per cycle, index 0..NUM_VOICES-1, for exactly NUM_VOICES cycles. Record:
    - first active voice with matching note (match);
    - lowest-index inactive voice (free);
    - active voice with largest age, ties resolved to the lowest index (oldest).
  - RESOLVE (1 cycle): pick the target voice and update the table (see below).
    - If no event is required: return to IDLE.
    - Otherwise: drive evt_* registers, set evt_valid=1, go to EMIT.
  - EMIT: hold evt_* stable while evt_valid=1 and evt_ready=0. When evt_valid & evt_ready, clear evt_valid and go to IDLE.
- Note-on resolution, in priority order:
  - match: retrigger that voice.
  - else free: allocate it.
  - else steal oldest.
  - Table update: target voice active=1, note=new note, age=0. Every other active voice's age increments, saturating at 2^AGE_W-1.
  - Event: evt_on=1, evt_note=note, evt_vel=vel.
- Note-off resolution:
  - match found: voice active=0, event evt_on=0, evt_vel=0, evt_note=note.
  - no match: no event, table unchanged.
- Latency: midi_rdy in cycle 0 → evt_valid=1 in cycle NUM_VOICES+2 (SEARCH occupies cycles 1..NUM_VOICES, RESOLVE is cycle NUM_VOICES+1).
- voice_active reflects the table after RESOLVE, i.e. it updates in the same cycle evt_valid rises.
- Sizing: at 100 MHz and the 31250-baud MIDI rate, the decoder cannot deliver back-to-back messages faster than about 320 us. drop_pulse therefore only fires if the consumer stalls evt_ready.

Decomposition:
- globals.vh holds the shared constants: MIDI_CMD_SIZE, MIDI_CMD_NOTE_ON, MIDI_CMD_NOTE_OFF (add the two codes if missing, shared with midi_decoder).
- One sub-module, voice_table:
  - storage for NUM_VOICES × {active, note[6:0], age[AGE_W-1:0]};
  - read port indexed by the scan counter;
  - single write/age-update command from RESOLVE.
- The FSM, scan comparators and event registers live in midi_voice_alloc.

Test Plan:
1. Reset, then NOTE_ON ch0 note 60 vel 100, evt_ready=1 → one event voice 0, on=1, note 60, vel 100, valid at cycle NUM_VOICES+2; voice_active=8'b0000_0001.
2. NOTE_ON notes 60..67 (8 voices), then NOTE_ON 72 → voices 0..7 allocated in order; note 72 steals voice 0 (oldest); exactly one event voice 0, on=1, note 72.
3. NOTE_ON 60, then NOTE_ON 64 vel 0 (no match), then NOTE_OFF 60 → only one extra event after the first: voice 0, on=0, note 60, vel 0; voice_active=0.
4. NOTE_ON 60 twice (vel 50, then 90) → both events target voice 0, second with vel 90; voice_active=8'b0000_0001.
5. Hold evt_ready=0 after NOTE_ON 60; send NOTE_ON 62 → evt_* stay stable, drop_pulse=1 once, no event for note 62. Then release evt_ready → single handshake completes, FSM returns to IDLE.
6. NOTE_ON on channel 3 (MIDI_CH=0), and reset asserted during SEARCH → no event, no drop_pulse, all outputs return to their reset values.
